control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
// - RV32I decode/execute slice of the 4-phase multicycle Core.
// - Decodes the fetched instruction into registered datapath controls.
// - Hosts the combinational ALU (alu_base) and the branch comparator.
// - Consumers: register-file selects, write-back mux, ALU operand muxes, data-memory write enable, PC-update logic.
// PARAMETERS
// - XLEN   32   datapath width; only 32 is supported.
// PORTS
// - clk               in   1   system clock; all state updates on posedge.
// - rst               in   1   synchronous, active-high reset.
// - instruction       in   32  fetched instruction word.
// - alu_a             in   32  ALU operand A (Core mux: rdata1 or PC).
// - alu_b             in   32  ALU operand B (Core mux: rdata2 or immediate).
// - rdata1, rdata2    in   32  register-file read data for branch compare.
// - RF_rsel1/RF_rsel2 out  5   rs1 = instr[19:15], rs2 = instr[24:20].
// - RF_wsel           out  5   rd = instr[11:7].
// - RF_wen            out  1   register write enable.
// - DM_wen            out  1   data-memory write enable.
// - RF_wdata_sel      out  2   write-back source: PC=00 (pc+4), ALU=01, DM=10; 11 is unused and decodes as 0.
// - ALU_OP1_SEL       out  1   REG=0, PC=1.
// - ALU_OP2_SEL       out  1   REG=0, IMM=1.
// - ALU_Operation     out  4   ALU control code.
// - branch_condition  out  3   branch compare selector.
// - alu_out           out  32  combinational ALU result.
// - branch_taken      out  1   1 = take branch; target is alu_out.
// BEHAVIOUR
// - Control outputs are registered: instruction sampled at posedge clk, outputs valid the next cycle.
//   - Latency 1 clk, well ahead of the read phase.
// - Reset state (rst high at posedge): RF_wen=0, DM_wen=0, selects=0, RF_wdata_sel=ALU, ALU_Operation=ADD, branch_condition=NEVER.
// - ALU codes ({funct7[5],funct3}):
//   - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100.
//   - SRL 0101, SRA 1101, OR 0110, AND 0111, PASS_B 1111.
//   - Any other code outputs 0.
// - ALU arithmetic rules:
//   - Arithmetic wraps mod 2^32.
//   - Shift amount is alu_b[4:0].
//   - SLT compares signed, SLTU unsigned; both return 0 or 1.
// - branch_condition:
//   - B-type: funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
//   - Non-branch instructions: NEVER=010. ALWAYS=011 is defined but never emitted.
// - branch_taken is combinational from branch_condition, rdata1 and rdata2.
// - Decode table (wen/wdata/op1/op2/alu):
//   - LUI 0110111: 1/ALU/-/IMM/PASS_B.
//   - AUIPC 0010111: 1/ALU/PC/IMM/ADD.
//   - JAL 1101111: 1/PC/PC/IMM/ADD.
//   - JALR 1100111: 1/PC/REG/IMM/ADD. Target LSB clearing is done by the PC logic, not here.
//   - BRANCH 1100011: 0/-/PC/IMM/ADD.
//   - LOAD 0000011: 1/DM/REG/IMM/ADD.
//   - STORE 0100011: 0/-/REG/IMM/ADD, DM_wen=1.
//   - OP-IMM 0010011: 1/ALU/REG/IMM; ALU code is {funct3==101 ? funct7[5] : 0, funct3}.
//   - OP 0110011: 1/ALU/REG/REG/{funct7[5],funct3}.
// - FENCE, SYSTEM and illegal opcodes: NOP, i.e. RF_wen=0, DM_wen=0, ADD, NEVER.
// - rd==x0 forces RF_wen=0.
// - Register selects are always the raw fields, even for formats that do not use them.
// - DM_wen is 1 only for STORE.
// - rst asserted mid-instruction: outputs return to reset state at that edge. There is no other internal state.
// STRUCTURE
// - Shared package rv32_pkg holds:
//   - opcode constants and ALU_* codes;
//   - BR_* conditions (including NEVER/ALWAYS);
//   - RF_WDATA_SEL_* and ALU_OP*_SEL_* encodings.
// - One sub-module, alu_base (pure combinational ALU).
// - Decode register and branch comparator are inline.
// TESTING
// - Reset: rst=1, then instruction=0x00000013 -> after reset release and 1 clk, RF_wen=0, then RF_wen=0 again (addi x0, rd=x0).
// - addi x5,x0,-1 (0xFFF00293) -> after 1 clk: RF_wen=1, wsel=5, op2=IMM, ALU=ADD.
//   - With alu_a=0, alu_b=0xFFFFFFFF: alu_out=0xFFFFFFFF.
// - sra x3,x1,x2 (0x4020D1B3), alu_a=0x80000000, alu_b=0x24 -> ALU=1101, alu_out=0xF8000000 (shamt 4).
// - blt x1,x2 (funct3 100), rdata1=0xFFFFFFFF, rdata2=1 -> branch_taken=1.
//   - bltu with the same data -> branch_taken=0.
//   - beq with rdata1=rdata2=7 -> branch_taken=1.
// - sw (0x0020A023) -> DM_wen=1, RF_wen=0. Following lw x4 (0x0000A203) -> DM_wen=0, RF_wen=1, RF_wdata_sel=DM.
// - jal x1,+8 (0x008000EF) -> RF_wdata_sel=PC, op1=PC, branch_condition=NEVER, RF_wen=1.
//   - Assert rst in the same cycle -> outputs return to reset values.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the multicycle core: opcodes, ALU control codes,
// branch-condition codes, datapath select encodings and the decode function
// that maps instruction fields onto one bundle of control bits.
package rv32_pkg;

  localparam int XLEN = 32;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU control codes, {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  // Branch conditions; B-type codes equal funct3
  localparam logic [2:0] BR_EQ     = 3'b000;
  localparam logic [2:0] BR_NE     = 3'b001;
  localparam logic [2:0] BR_NEVER  = 3'b010;
  localparam logic [2:0] BR_ALWAYS = 3'b011;
  localparam logic [2:0] BR_LT     = 3'b100;
  localparam logic [2:0] BR_GE     = 3'b101;
  localparam logic [2:0] BR_LTU    = 3'b110;
  localparam logic [2:0] BR_GEU    = 3'b111;

  // Write-back source and ALU operand selects
  localparam logic [1:0] RF_WDATA_SEL_PC  = 2'b00;
  localparam logic [1:0] RF_WDATA_SEL_ALU = 2'b01;
  localparam logic [1:0] RF_WDATA_SEL_DM  = 2'b10;
  localparam logic       ALU_OP1_SEL_REG  = 1'b0;
  localparam logic       ALU_OP1_SEL_PC   = 1'b1;
  localparam logic       ALU_OP2_SEL_REG  = 1'b0;
  localparam logic       ALU_OP2_SEL_IMM  = 1'b1;

  typedef struct packed {
    logic       rf_wen;
    logic       dm_wen;
    logic [1:0] wdata_sel;
    logic       op1_sel;
    logic       op2_sel;
    logic [3:0] alu_op;
    logic [2:0] br_cond;
  } ctrl_t;

  // Reset state and the NOP decode share one value.
  localparam ctrl_t CTRL_NOP = '{
    rf_wen:    1'b0,
    dm_wen:    1'b0,
    wdata_sel: RF_WDATA_SEL_ALU,
    op1_sel:   ALU_OP1_SEL_REG,
    op2_sel:   ALU_OP2_SEL_REG,
    alu_op:    ALU_ADD,
    br_cond:   BR_NEVER
  };

  function automatic ctrl_t decode(input logic [6:0] opcode,
                                   input logic [2:0] funct3,
                                   input logic       funct7b5,
                                   input logic       rd_zero);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OPC_LUI: begin
        c.rf_wen  = 1'b1;
        c.op2_sel = ALU_OP2_SEL_IMM;
        c.alu_op  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        c.rf_wen  = 1'b1;
        c.op1_sel = ALU_OP1_SEL_PC;
        c.op2_sel = ALU_OP2_SEL_IMM;
      end
      OPC_JAL: begin
        c.rf_wen    = 1'b1;
        c.wdata_sel = RF_WDATA_SEL_PC;
        c.op1_sel   = ALU_OP1_SEL_PC;
        c.op2_sel   = ALU_OP2_SEL_IMM;
      end
      OPC_JALR: begin
        c.rf_wen    = 1'b1;
        c.wdata_sel = RF_WDATA_SEL_PC;
        c.op2_sel   = ALU_OP2_SEL_IMM;
      end
      OPC_BRANCH: begin
        c.op1_sel = ALU_OP1_SEL_PC;
        c.op2_sel = ALU_OP2_SEL_IMM;
        // funct3 010/011 are not branches; keep them from aliasing NEVER/ALWAYS
        c.br_cond = (funct3[2:1] == 2'b01) ? BR_NEVER : funct3;
      end
      OPC_LOAD: begin
        c.rf_wen    = 1'b1;
        c.wdata_sel = RF_WDATA_SEL_DM;
        c.op2_sel   = ALU_OP2_SEL_IMM;
      end
      OPC_STORE: begin
        c.dm_wen  = 1'b1;
        c.op2_sel = ALU_OP2_SEL_IMM;
      end
      OPC_OP_IMM: begin
        c.rf_wen  = 1'b1;
        c.op2_sel = ALU_OP2_SEL_IMM;
        // imm[10] only selects SRA for shifts; for ADDI etc. it is immediate data
        c.alu_op  = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
      end
      OPC_OP: begin
        c.rf_wen = 1'b1;
        c.alu_op = {funct7b5, funct3};
      end
      default: ;
    endcase
    if (rd_zero) c.rf_wen = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/alu_base.sv
// Combinational RV32I ALU.
//   op  : 4-bit ALU control code (ALU_* in rv32_pkg)
//   a,b : operands; shift amount is b[4:0]
//   y   : result; unknown codes yield 0
module alu_base
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I decode/execute slice of the 4-phase multicycle core.
// Registers the decoded controls one cycle after the instruction is sampled,
// and hosts the ALU and branch comparator, both combinational.
//   clk, rst                 : clock, synchronous active-high reset
//   instruction              : fetched instruction word
//   alu_a, alu_b             : ALU operands (muxed by the core)
//   rdata1, rdata2           : register data for branch compare
//   RF_rsel1/2, RF_wsel      : rs1, rs2, rd fields (raw, always passed through)
//   RF_wen, DM_wen           : register / data-memory write enables
//   RF_wdata_sel             : write-back source
//   ALU_OP1_SEL, ALU_OP2_SEL : operand selects
//   ALU_Operation            : ALU control code
//   branch_condition         : branch compare selector
//   alu_out, branch_taken    : combinational ALU result and branch decision
module control_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [4:0]      RF_rsel1,
  output logic [4:0]      RF_rsel2,
  output logic [4:0]      RF_wsel,
  output logic            RF_wen,
  output logic            DM_wen,
  output logic [1:0]      RF_wdata_sel,
  output logic            ALU_OP1_SEL,
  output logic            ALU_OP2_SEL,
  output logic [3:0]      ALU_Operation,
  output logic [2:0]      branch_condition,
  output logic [XLEN-1:0] alu_out,
  output logic            branch_taken
);

  ctrl_t ctrl_d;
  assign ctrl_d = decode(instruction[6:0], instruction[14:12], instruction[30],
                         instruction[11:7] == 5'd0);

  // Immediate-only bits are consumed by the core's immediate generator.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{instruction[31], instruction[29:25]};

  always_ff @(posedge clk) begin
    if (rst) begin
      RF_rsel1         <= '0;
      RF_rsel2         <= '0;
      RF_wsel          <= '0;
      RF_wen           <= CTRL_NOP.rf_wen;
      DM_wen           <= CTRL_NOP.dm_wen;
      RF_wdata_sel     <= CTRL_NOP.wdata_sel;
      ALU_OP1_SEL      <= CTRL_NOP.op1_sel;
      ALU_OP2_SEL      <= CTRL_NOP.op2_sel;
      ALU_Operation    <= CTRL_NOP.alu_op;
      branch_condition <= CTRL_NOP.br_cond;
    end else begin
      RF_rsel1         <= instruction[19:15];
      RF_rsel2         <= instruction[24:20];
      RF_wsel          <= instruction[11:7];
      RF_wen           <= ctrl_d.rf_wen;
      DM_wen           <= ctrl_d.dm_wen;
      RF_wdata_sel     <= ctrl_d.wdata_sel;
      ALU_OP1_SEL      <= ctrl_d.op1_sel;
      ALU_OP2_SEL      <= ctrl_d.op2_sel;
      ALU_Operation    <= ctrl_d.alu_op;
      branch_condition <= ctrl_d.br_cond;
    end
  end

  alu_base #(.XLEN(XLEN)) u_alu (
    .op (ALU_Operation),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_out)
  );

  always_comb begin
    branch_taken = 1'b0;
    case (branch_condition)
      BR_EQ:     branch_taken = (rdata1 == rdata2);
      BR_NE:     branch_taken = (rdata1 != rdata2);
      BR_LT:     branch_taken = ($signed(rdata1) <  $signed(rdata2));
      BR_GE:     branch_taken = ($signed(rdata1) >= $signed(rdata2));
      BR_LTU:    branch_taken = (rdata1 <  rdata2);
      BR_GEU:    branch_taken = (rdata1 >= rdata2);
      BR_ALWAYS: branch_taken = 1'b1;
      default:   branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, alu_a, alu_b, rdata1, rdata2;
  logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
  logic        RF_wen, DM_wen, ALU_OP1_SEL, ALU_OP2_SEL, branch_taken;
  logic [1:0]  RF_wdata_sel;
  logic [3:0]  ALU_Operation;
  logic [2:0]  branch_condition;
  logic [31:0] alu_out;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .RF_rsel1         (RF_rsel1),
    .RF_rsel2         (RF_rsel2),
    .RF_wsel          (RF_wsel),
    .RF_wen           (RF_wen),
    .DM_wen           (DM_wen),
    .RF_wdata_sel     (RF_wdata_sel),
    .ALU_OP1_SEL      (ALU_OP1_SEL),
    .ALU_OP2_SEL      (ALU_OP2_SEL),
    .ALU_Operation    (ALU_Operation),
    .branch_condition (branch_condition),
    .alu_out          (alu_out),
    .branch_taken     (branch_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".RF_wen"},  32'(RF_wen), 32'd0);
    chk({tag, ".DM_wen"},  32'(DM_wen), 32'd0);
    chk({tag, ".wdata"},   32'(RF_wdata_sel), 32'd1);
    chk({tag, ".op1"},     32'(ALU_OP1_SEL), 32'd0);
    chk({tag, ".op2"},     32'(ALU_OP2_SEL), 32'd0);
    chk({tag, ".alu"},     32'(ALU_Operation), 32'd0);
    chk({tag, ".br"},      32'(branch_condition), 32'd2);
    chk({tag, ".sels"},    {17'd0, RF_rsel1, RF_rsel2, RF_wsel}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; instruction = 32'h0000_0013;
    alu_a = '0; alu_b = '0; rdata1 = '0; rdata2 = '0;
    #1;
    step(); step();
    chk_reset_state("reset");

    // addi x0,x0,0 : rd=x0 keeps RF_wen low
    rst = 1'b0;
    step();
    chk("nop1.RF_wen", 32'(RF_wen), 32'd0);
    chk("nop1.alu",    32'(ALU_Operation), 32'd0);
    step();
    chk("nop2.RF_wen", 32'(RF_wen), 32'd0);

    // addi x5,x0,-1
    instruction = 32'hFFF0_0293; alu_a = 32'h0; alu_b = 32'hFFFF_FFFF;
    step();
    chk("addi.RF_wen", 32'(RF_wen), 32'd1);
    chk("addi.wsel",   32'(RF_wsel), 32'd5);
    chk("addi.op2",    32'(ALU_OP2_SEL), 32'd1);
    chk("addi.alu",    32'(ALU_Operation), 32'd0);
    chk("addi.wdata",  32'(RF_wdata_sel), 32'd1);
    chk("addi.out",    alu_out, 32'hFFFF_FFFF);

    // sra x3,x1,x2 : shamt = 0x24[4:0] = 4
    instruction = 32'h4020_D1B3; alu_a = 32'h8000_0000; alu_b = 32'h0000_0024;
    step();
    chk("sra.alu",   32'(ALU_Operation), 32'hD);
    chk("sra.out",   alu_out, 32'hF800_0000);
    chk("sra.rsel1", 32'(RF_rsel1), 32'd1);
    chk("sra.rsel2", 32'(RF_rsel2), 32'd2);
    chk("sra.wsel",  32'(RF_wsel), 32'd3);
    chk("sra.op2",   32'(ALU_OP2_SEL), 32'd0);

    // add wraps
    instruction = 32'h0020_80B3; alu_a = 32'hFFFF_FFFF; alu_b = 32'h2;
    step();
    chk("add.out", alu_out, 32'h1);
    // slt / sltu with -1 vs 1
    instruction = 32'h0020_A0B3; alu_b = 32'h1;
    step();
    chk("slt.alu", 32'(ALU_Operation), 32'h2);
    chk("slt.out", alu_out, 32'h1);
    instruction = 32'h0020_B0B3;
    step();
    chk("sltu.out", alu_out, 32'h0);
    // OP with funct7[5]=1, funct3=001 -> undefined code 1001 -> 0
    instruction = 32'h4020_90B3; alu_a = 32'h5; alu_b = 32'h1;
    step();
    chk("bad.alu", 32'(ALU_Operation), 32'h9);
    chk("bad.out", alu_out, 32'h0);

    // addi with imm[10]=1 stays ADD; srai/srli pick by imm[10]
    instruction = 32'h4000_8093; alu_a = 32'h1; alu_b = 32'h2;
    step();
    chk("addi_b30.alu", 32'(ALU_Operation), 32'h0);
    chk("addi_b30.out", alu_out, 32'h3);
    instruction = 32'h4030_D093; alu_a = 32'hF000_0000; alu_b = 32'h3;
    step();
    chk("srai.out", alu_out, 32'hFE00_0000);
    instruction = 32'h0030_D093;
    step();
    chk("srli.out", alu_out, 32'h1E00_0000);

    // lui passes B
    instruction = 32'h1234_50B7; alu_a = 32'hDEAD_BEEF; alu_b = 32'h1234_5000;
    step();
    chk("lui.alu", 32'(ALU_Operation), 32'hF);
    chk("lui.out", alu_out, 32'h1234_5000);
    chk("lui.wen", 32'(RF_wen), 32'd1);

    // branches: rdata1=-1, rdata2=1
    rdata1 = 32'hFFFF_FFFF; rdata2 = 32'h1;
    instruction = 32'h0020_C063;  // blt
    step();
    chk("blt.br",    32'(branch_condition), 32'd4);
    chk("blt.wen",   32'(RF_wen), 32'd0);
    chk("blt.op1",   32'(ALU_OP1_SEL), 32'd1);
    chk("blt.op2",   32'(ALU_OP2_SEL), 32'd1);
    chk("blt.taken", 32'(branch_taken), 32'd1);
    instruction = 32'h0020_E063;  // bltu
    step();
    chk("bltu.taken", 32'(branch_taken), 32'd0);
    instruction = 32'h0020_F063;  // bgeu
    step();
    chk("bgeu.taken", 32'(branch_taken), 32'd1);
    rdata1 = 32'h7; rdata2 = 32'h7;
    instruction = 32'h0020_8063;  // beq
    step();
    chk("beq.taken", 32'(branch_taken), 32'd1);
    instruction = 32'h0020_9063;  // bne
    step();
    chk("bne.taken", 32'(branch_taken), 32'd0);

    // sw then lw x4
    instruction = 32'h0020_A023;
    step();
    chk("sw.DM_wen", 32'(DM_wen), 32'd1);
    chk("sw.RF_wen", 32'(RF_wen), 32'd0);
    chk("sw.br",     32'(branch_condition), 32'd2);
    instruction = 32'h0000_A203;
    step();
    chk("lw.DM_wen", 32'(DM_wen), 32'd0);
    chk("lw.RF_wen", 32'(RF_wen), 32'd1);
    chk("lw.wdata",  32'(RF_wdata_sel), 32'd2);
    chk("lw.wsel",   32'(RF_wsel), 32'd4);

    // ecall is a NOP
    instruction = 32'h0000_0073;
    step();
    chk("ecall.wen", 32'(RF_wen), 32'd0);
    chk("ecall.br",  32'(branch_condition), 32'd2);

    // jal x1,+8
    instruction = 32'h0080_00EF;
    step();
    chk("jal.wdata", 32'(RF_wdata_sel), 32'd0);
    chk("jal.op1",   32'(ALU_OP1_SEL), 32'd1);
    chk("jal.br",    32'(branch_condition), 32'd2);
    chk("jal.wen",   32'(RF_wen), 32'd1);

    // reset with jal still on the bus
    rst = 1'b1;
    step();
    chk_reset_state("rst_mid");
    rst = 1'b0;
    step();
    chk("jal2.wen", 32'(RF_wen), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
